// File: rtl/wb_arb_pkg.sv
// Shared types for the gateway Wishbone arbiter: FSM states, arbitration policy,
// and default bus widths.
`ifndef UART_ADDR_WIDTH
`define UART_ADDR_WIDTH 8
`endif
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 32
`endif

package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  // Watchdog counter width; a disabled watchdog still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational request arbiter: returns the one-hot winner. In fixed mode the
// search starts at index 0; in round-robin mode it starts at ptr and wraps.
module rr_arbiter_core
  import wb_arb_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  arb_mode_t        mode,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             valid
);

  int unsigned      base;
  logic [IDX_W-1:0] sel;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    sel        = '0;
    base       = (mode == ARB_RR) ? int'(ptr) : 0;
    for (int unsigned k = 0; k < N; k++) begin
      sel = IDX_W'((base + k) % N);
      if (!valid && req[sel]) begin
        valid       = 1'b1;
        winner[sel] = 1'b1;
        winner_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/wishbone_arbiter_n.sv
// N-master to single-slave Wishbone classic arbiter with fixed/round-robin policy,
// per-cycle bus lock and a watchdog that aborts hung slave cycles.
module wishbone_arbiter_n
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned ADDR_W      = `UART_ADDR_WIDTH,
  parameter int unsigned DATA_W      = `UART_DATA_WIDTH,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode,
  input  logic [NUM_MASTERS-1:0]        m_cyc,
  input  logic [NUM_MASTERS-1:0]        m_stb,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr,
  input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_w,
  output logic [DATA_W-1:0]             m_dat_r,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic                          s_cyc,
  output logic                          s_stb,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_adr,
  output logic [SEL_W-1:0]              s_sel,
  output logic [DATA_W-1:0]             s_dat_w,
  input  logic [DATA_W-1:0]             s_dat_r,
  input  logic                          s_ack,
  input  logic                          s_err,
  output logic [NUM_MASTERS-1:0]        grant,
  output logic                          timeout_evt
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYC);

  arb_state_t             state;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       next_ptr;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_MASTERS-1:0] err_pulse;

  logic [NUM_MASTERS-1:0] winner;
  logic [IDX_W-1:0]       winner_idx;
  logic                   arb_valid;

  logic busy;
  logic own_cyc;
  logic own_stb;
  logic own_we;
  logic wd_fire;

  rr_arbiter_core #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_core (
    .req        (m_cyc),
    .ptr        (rr_ptr),
    .mode       (arb_mode_t'(mode)),
    .winner     (winner),
    .winner_idx (winner_idx),
    .valid      (arb_valid)
  );

  // Owner's request, muxed combinationally so each beat adds no latency.
  assign busy    = (state == BUSY);
  assign own_cyc = |(grant & m_cyc);
  assign own_stb = |(grant & m_stb);
  assign own_we  = |(grant & m_we);

  assign s_cyc   = busy & own_cyc;
  assign s_stb   = s_cyc & own_stb;
  assign s_we    = busy & own_we;
  assign m_dat_r = s_dat_r;

  always_comb begin
    s_adr   = '0;
    s_sel   = '0;
    s_dat_w = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (busy && grant[i]) begin
        s_adr   = s_adr   | m_adr[i*ADDR_W +: ADDR_W];
        s_sel   = s_sel   | m_sel[i*SEL_W +: SEL_W];
        s_dat_w = s_dat_w | m_dat_w[i*DATA_W +: DATA_W];
      end
    end
  end

  // Responses reach only the owner; a watchdog abort adds a one-cycle error.
  assign m_ack = busy ? (grant & {NUM_MASTERS{s_ack}}) : '0;
  assign m_err = (busy ? (grant & {NUM_MASTERS{s_err}}) : '0) | err_pulse;

  assign next_ptr = (owner == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner + IDX_W'(1);

  assign wd_fire = (TIMEOUT_CYC != 0) && s_stb && !s_ack && !s_err &&
                   (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
      err_pulse   <= '0;
      timeout_evt <= 1'b0;
    end else begin
      err_pulse   <= '0;
      timeout_evt <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant <= winner;
            owner <= winner_idx;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!own_cyc) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= next_ptr;
          end else if (wd_fire) begin
            state       <= ABORT;
            timeout_evt <= 1'b1;
            err_pulse   <= grant;
          end else if (s_ack || s_err) begin
            cnt <= '0;
          end else if (s_stb && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ABORT: begin
          if (!own_cyc) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter_n.sv
// Directed bench for wishbone_arbiter_n: a vector table for single-beat routing
// plus hand-written round-robin, bus-lock, watchdog and reset sequences.
module tb_wishbone_arbiter_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [2:0]  m_cyc, m_stb, m_we;
  logic [23:0] m_adr;
  logic [11:0] m_sel;
  logic [95:0] m_dat_w;
  logic [31:0] m_dat_r;
  logic [2:0]  m_ack, m_err;
  logic        s_cyc, s_stb, s_we;
  logic [7:0]  s_adr;
  logic [3:0]  s_sel;
  logic [31:0] s_dat_w, s_dat_r;
  logic        s_ack, s_err;
  logic [2:0]  grant;
  logic        timeout_evt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wishbone_arbiter_n #(
    .NUM_MASTERS (3),
    .ADDR_W      (8),
    .DATA_W      (32),
    .SEL_W       (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .m_cyc       (m_cyc),
    .m_stb       (m_stb),
    .m_we        (m_we),
    .m_adr       (m_adr),
    .m_sel       (m_sel),
    .m_dat_w     (m_dat_w),
    .m_dat_r     (m_dat_r),
    .m_ack       (m_ack),
    .m_err       (m_err),
    .s_cyc       (s_cyc),
    .s_stb       (s_stb),
    .s_we        (s_we),
    .s_adr       (s_adr),
    .s_sel       (s_sel),
    .s_dat_w     (s_dat_w),
    .s_dat_r     (s_dat_r),
    .s_ack       (s_ack),
    .s_err       (s_err),
    .grant       (grant),
    .timeout_evt (timeout_evt)
  );

  typedef struct {
    logic [2:0] cyc, stb;
    logic       ack, err;
    logic [2:0] e_grant;
    logic       e_scyc, e_sstb, e_swe;
    logic [7:0] e_adr;
    logic [2:0] e_ack, e_err;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_grant(output logic [2:0] g);
    g = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      #1;
      if (grant != 3'b000) begin
        g = grant;
        break;
      end
    end
    if (g == 3'b000) begin
      checks++;
      failures++;
      $display("FAIL wait_grant: got no grant within 10 cycles at %0t", $time);
    end
  endtask

  logic [2:0] g;
  logic [2:0] rr_exp [4];

  initial begin
    //          cyc     stb     ack   err   grant   scyc  sstb  swe   adr    ack     err
    vecs[0]  = '{3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 3'b000};
    vecs[1]  = '{3'b010, 3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 3'b000};
    vecs[2]  = '{3'b010, 3'b010, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 8'h11, 3'b000, 3'b000};
    vecs[3]  = '{3'b010, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 8'h11, 3'b010, 3'b000};
    vecs[4]  = '{3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 8'h11, 3'b000, 3'b000};
    vecs[5]  = '{3'b101, 3'b101, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 3'b000};
    vecs[6]  = '{3'b101, 3'b101, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 8'h10, 3'b001, 3'b000};
    vecs[7]  = '{3'b100, 3'b100, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 8'h10, 3'b000, 3'b000};
    vecs[8]  = '{3'b100, 3'b100, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 3'b000};
    vecs[9]  = '{3'b100, 3'b110, 1'b1, 1'b1, 3'b100, 1'b1, 1'b1, 1'b1, 8'h12, 3'b100, 3'b100};
    vecs[10] = '{3'b000, 3'b000, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 8'h12, 3'b000, 3'b000};
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

    rst     = 1'b1;
    mode    = 1'b0;
    m_cyc   = '0;
    m_stb   = '0;
    m_we    = 3'b100;
    m_adr   = {8'h12, 8'h11, 8'h10};
    m_sel   = {4'h4, 4'h2, 4'h1};
    m_dat_w = {32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    s_dat_r = 32'h0000_00A5;
    s_ack   = 1'b0;
    s_err   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_grant", grant, 3'b000);
    chk("reset_s_cyc", s_cyc, 1'b0);
    chk("reset_s_adr", s_adr, 8'h00);
    chk("reset_m_ack", m_ack, 3'b000);
    chk("reset_evt", timeout_evt, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Fixed-priority single-beat table
    foreach (vecs[i]) begin
      @(negedge clk);
      m_cyc = vecs[i].cyc;
      m_stb = vecs[i].stb;
      s_ack = vecs[i].ack;
      s_err = vecs[i].err;
      #1;
      chk($sformatf("v%0d_grant", i), grant, vecs[i].e_grant);
      chk($sformatf("v%0d_s_cyc", i), s_cyc, vecs[i].e_scyc);
      chk($sformatf("v%0d_s_stb", i), s_stb, vecs[i].e_sstb);
      chk($sformatf("v%0d_s_we", i), s_we, vecs[i].e_swe);
      chk($sformatf("v%0d_s_adr", i), s_adr, vecs[i].e_adr);
      chk($sformatf("v%0d_m_ack", i), m_ack, vecs[i].e_ack);
      chk($sformatf("v%0d_m_err", i), m_err, vecs[i].e_err);
      if (i == 3) chk("v3_m_dat_r", m_dat_r, 32'h0000_00A5);
      if (i == 9) begin
        chk("v9_s_sel", s_sel, 4'h4);
        chk("v9_s_dat_w", s_dat_w, 32'h1000_0002);
      end
    end
    @(negedge clk);
    s_ack = 1'b0;
    s_err = 1'b0;

    // Round-robin: all three hold requests, one beat each
    mode = 1'b1;
    @(negedge clk);
    m_cyc = 3'b111;
    m_stb = 3'b111;
    for (int r = 0; r < 4; r++) begin
      wait_grant(g);
      chk($sformatf("rr%0d_grant", r), g, rr_exp[r]);
      @(negedge clk);
      s_ack = 1'b1;
      #1;
      chk($sformatf("rr%0d_m_ack", r), m_ack, rr_exp[r]);
      @(negedge clk);
      s_ack = 1'b0;
      if (r == 3) begin
        m_cyc = '0;
        m_stb = '0;
      end else begin
        m_cyc = m_cyc & ~rr_exp[r];
        m_stb = m_stb & ~rr_exp[r];
        @(negedge clk);
        m_cyc = m_cyc | rr_exp[r];
        m_stb = m_stb | rr_exp[r];
      end
    end
    @(negedge clk);

    // Bus lock: master 1 burst of 4 while master 0 waits
    mode = 1'b0;
    @(negedge clk);
    m_cyc = 3'b010;
    m_stb = 3'b010;
    wait_grant(g);
    chk("lock_first_grant", g, 3'b010);
    @(negedge clk);
    m_cyc = 3'b011;
    m_stb = 3'b011;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      s_ack = 1'b1;
      #1;
      chk($sformatf("lock%0d_m_ack", b), m_ack, 3'b010);
      chk($sformatf("lock%0d_grant", b), grant, 3'b010);
      @(negedge clk);
      s_ack = 1'b0;
    end
    m_cyc = 3'b001;
    m_stb = 3'b001;
    @(negedge clk);
    #1;
    chk("lock_rearb_gap", grant, 3'b000);
    wait_grant(g);
    chk("lock_next_grant", g, 3'b001);
    @(negedge clk);
    m_cyc = '0;
    m_stb = '0;
    @(negedge clk);

    // Watchdog: master 2, slave never responds
    @(negedge clk);
    m_cyc = 3'b100;
    m_stb = 3'b100;
    wait_grant(g);
    chk("wd_grant", g, 3'b100);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      if (k < 8) begin
        chk($sformatf("wd%0d_evt", k), timeout_evt, 1'b0);
        chk($sformatf("wd%0d_s_stb", k), s_stb, 1'b1);
      end else begin
        chk("wd_fire_evt", timeout_evt, 1'b1);
        chk("wd_fire_m_err", m_err, 3'b100);
        chk("wd_fire_s_cyc", s_cyc, 1'b0);
        chk("wd_fire_grant", grant, 3'b100);
      end
    end
    @(negedge clk);
    #1;
    chk("wd_abort_evt", timeout_evt, 1'b0);
    chk("wd_abort_m_err", m_err, 3'b000);
    chk("wd_abort_grant", grant, 3'b100);
    chk("wd_abort_s_stb", s_stb, 1'b0);
    m_cyc = '0;
    m_stb = '0;
    @(negedge clk);
    #1;
    chk("wd_idle_grant", grant, 3'b000);

    // Reset during BUSY, then round-robin must restart at pointer 0
    mode = 1'b1;
    @(negedge clk);
    m_cyc = 3'b001;
    m_stb = 3'b001;
    wait_grant(g);
    chk("pre_rst_grant0", g, 3'b001);
    @(negedge clk);
    m_cyc = '0;
    m_stb = '0;
    @(negedge clk);
    m_cyc = 3'b100;
    m_stb = 3'b100;
    wait_grant(g);
    chk("pre_rst_grant2", g, 3'b100);
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    chk("pre_rst_m_ack", m_ack, 3'b100);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_grant", grant, 3'b000);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_m_ack", m_ack, 3'b000);
    @(negedge clk);
    rst   = 1'b0;
    s_ack = 1'b0;
    m_cyc = 3'b011;
    m_stb = 3'b011;
    wait_grant(g);
    chk("post_rst_grant", g, 3'b001);
    @(negedge clk);
    m_cyc = '0;
    m_stb = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter_n.md
# wishbone_arbiter_n

Parametrised N-master to single-slave Wishbone classic arbiter; the next-generation replacement for the fixed 3-to-1 select mux inside the UART gateway. Arbitrates live among the gateway's masters (uart config, handshake, xmodem, plus future agents) with selectable fixed-priority or round-robin policy. Holds a grant for a whole bus cycle and terminates hung slave cycles with a watchdog error. Sits between the gateway masters and the UART IP wishbone slave port.

## Interface
- NUM_MASTERS, 3, number of requesting masters (2..8)
- ADDR_W, `UART_ADDR_WIDTH, address width
- DATA_W, `UART_DATA_WIDTH, data width
- SEL_W, 4, byte-select width
- TIMEOUT_CYC, 255, watchdog limit in cycles; 0 disables watchdog
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- mode  in  1  0 = fixed priority (master 0 highest), 1 = round-robin; sampled only in IDLE
- m_cyc, m_stb, m_we  in  NUM_MASTERS each  per-master cycle/strobe/write
- m_adr  in  NUM_MASTERS*ADDR_W  packed per-master address
- m_sel  in  NUM_MASTERS*SEL_W  packed byte selects
- m_dat_w  in  NUM_MASTERS*DATA_W  packed write data
- m_dat_r  out  DATA_W  slave read data, broadcast to all masters
- m_ack, m_err  out  NUM_MASTERS  per-master acknowledge/error
- s_cyc, s_stb, s_we  out  1  slave-side cycle/strobe/write
- s_adr, s_sel, s_dat_w  out  ADDR_W / SEL_W / DATA_W  slave request fields
- s_dat_r  in  DATA_W  slave read data
- s_ack, s_err  in  1  slave acknowledge/error
- grant  out  NUM_MASTERS  one-hot current owner, 0 when idle
- timeout_evt  out  1  one-cycle pulse when watchdog fires

## Operation
- FSM states: IDLE, BUSY, ABORT.
- IDLE: if any m_cyc high, select winner, register grant, go BUSY. Fixed: lowest index wins. Round-robin: first requester at or after rr_ptr, wrapping modulo NUM_MASTERS.
- BUSY: slave fields muxed from granted master; s_cyc/s_stb follow granted m_cyc/m_stb. s_ack/s_err routed only to granted master; others see 0. Grant held across multiple stb beats while m_cyc stays high (bus lock).
- BUSY -> IDLE when granted m_cyc falls; rr_ptr <= granted index + 1 (wrap to 0 at NUM_MASTERS).
- Watchdog: counter clears on entering BUSY and on every s_ack/s_err; increments each cycle s_stb high without ack/err. On reaching TIMEOUT_CYC: pulse m_err to owner and timeout_evt for one cycle, drop s_cyc/s_stb, go ABORT.
- ABORT: slave outputs low, grant held; wait for owner m_cyc low, then IDLE with rr_ptr update as above.
- s_ack and s_err together: both forwarded; counter cleared.
- Ungranted masters' m_stb ignored; no response generated.

## Timing
- Reset: state IDLE, grant 0, rr_ptr 0, counter 0, s_cyc/s_stb/s_we 0, s_adr/s_sel/s_dat_w 0, m_ack/m_err 0, timeout_evt 0.
- Arbitration latency: 1 cycle from m_cyc rise in IDLE to grant/s_cyc high.
- Slave request and response paths combinational once granted (zero added latency per beat).
- Minimum 1 IDLE cycle between consecutive grants (re-arbitration cycle).
- Request dropped in same cycle as grant registered: BUSY entered, exits next cycle; no slave stb issued.
- Watchdog fires exactly TIMEOUT_CYC cycles after stb rise with no response; counter width clog2(TIMEOUT_CYC+1), saturating.
- rst mid-cycle: all outputs to reset values immediately; in-flight transfer lost, no ack/err.

## Structure
- Package wb_arb_pkg: arb_state_t enum (IDLE, BUSY, ABORT), arb_mode_t enum (ARB_FIXED, ARB_RR).
- Sub-module rr_arbiter_core: combinational request vector + rr_ptr + mode -> one-hot winner; reusable by other interconnect blocks.

## Test plan
- Single master: m_cyc[1] rises -> grant=3'b010 next cycle, read returns s_dat_r 0xA5 with m_ack[1] same cycle as s_ack.
- Fixed priority: masters 0 and 2 request together -> grant 3'b001; master 2 granted only after master 0 drops cyc.
- Round-robin: all three hold requests, each does one beat -> grant order 0,1,2,0.
- Bus lock: master 1 performs 4-beat burst with cyc held, master 0 requesting -> grant stays 3'b010 for all 4 acks.
- Watchdog TIMEOUT_CYC=8, slave never acks -> m_err[owner] and timeout_evt pulse at cycle 8 after stb, s_cyc low, IDLE after owner drops cyc.
- rst asserted during BUSY -> grant, s_cyc, m_ack clear asynchronously; next request arbitrates with rr_ptr=0.
